// File: rtl/pocket_array_draw.sv
// rtl/pocket_array_draw.sv - N-pocket position, draw request and hit/flash tracker
module pocket_array_draw #(
  parameter int NUM_POCKETS  = 6,
  parameter int TABLE_LEFT   = 24,
  parameter int TABLE_TOP    = 24,
  parameter int TABLE_W      = 592,
  parameter int TABLE_H      = 432,
  parameter int POCKET_SIZE  = 10,
  parameter int GROW         = 2,
  parameter int FLASH_FRAMES = 15
) (
  input  logic                           clk,
  input  logic                           resetN,
  input  logic                           startOfFrame,
  input  logic signed [10:0]             pixelX,
  input  logic signed [10:0]             pixelY,
  input  logic                           pocketHit,
  input  logic [$clog2(NUM_POCKETS)-1:0] pocketHitIdx,
  input  logic                           clearHits,
  output logic                           drawingRequest,
  output logic [$clog2(NUM_POCKETS)-1:0] pocketId,
  output logic signed [10:0]             offsetX,
  output logic signed [10:0]             offsetY,
  output logic [NUM_POCKETS-1:0]         flashMask,
  output logic [7:0]                     totalHits
);

  localparam int IW   = $clog2(NUM_POCKETS);
  localparam int C    = NUM_POCKETS / 2;
  localparam int STEP = (TABLE_W - POCKET_SIZE) / (C - 1);
  localparam int YBOT = TABLE_TOP + TABLE_H - POCKET_SIZE;

  localparam logic signed [10:0] GROW_S    = 11'(GROW);
  localparam logic signed [10:0] SIZE_M1_S = 11'(POCKET_SIZE - 1);
  localparam logic [7:0]         FLASH_LD  = 8'(FLASH_FRAMES);

  // Nominal top-left corner of pocket i; row 0 is the top row
  function automatic logic signed [10:0] pocket_x(input int i);
    pocket_x = 11'(TABLE_LEFT + (i % C) * STEP);
  endfunction

  function automatic logic signed [10:0] pocket_y(input int i);
    pocket_y = (i / C == 0) ? 11'(TABLE_TOP) : 11'(YBOT);
  endfunction

  logic [7:0]        cnt [NUM_POCKETS];
  logic              hit_ok;
  logic              draw_n;
  logic [IW-1:0]     id_n;
  logic signed [10:0] offx_n, offy_n;
  logic signed [10:0] g, lx, ly, rx, ry;

  assign hit_ok = pocketHit && (int'(pocketHitIdx) < NUM_POCKETS);

  // A pocket flashes while its frame counter is nonzero
  always_comb begin
    flashMask = '0;
    for (int i = 0; i < NUM_POCKETS; i++) begin
      flashMask[i] = (cnt[i] != 8'd0);
    end
  end

  // Find the lowest-index box (grown if flashing) containing the pixel
  always_comb begin
    draw_n = 1'b0;
    id_n   = '0;
    offx_n = '0;
    offy_n = '0;
    g  = '0;
    lx = '0;
    ly = '0;
    rx = '0;
    ry = '0;
    for (int i = 0; i < NUM_POCKETS; i++) begin
      g  = flashMask[i] ? GROW_S : 11'sd0;
      lx = pocket_x(i) - g;
      ly = pocket_y(i) - g;
      rx = pocket_x(i) + SIZE_M1_S + g;
      ry = pocket_y(i) + SIZE_M1_S + g;
      if (!draw_n && pixelX >= lx && pixelX <= rx && pixelY >= ly && pixelY <= ry) begin
        draw_n = 1'b1;
        id_n   = IW'(i);
        offx_n = pixelX - lx;
        offy_n = pixelY - ly;
      end
    end
  end

  // Register the draw result for one-clock latency
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      drawingRequest <= 1'b0;
      pocketId       <= '0;
      offsetX        <= '0;
      offsetY        <= '0;
    end else begin
      drawingRequest <= draw_n;
      pocketId       <= id_n;
      offsetX        <= offx_n;
      offsetY        <= offy_n;
    end
  end

  // Flash counters: clear beats hit-load, hit-load beats frame decrement
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < NUM_POCKETS; i++) cnt[i] <= 8'd0;
    end else if (clearHits) begin
      for (int i = 0; i < NUM_POCKETS; i++) cnt[i] <= 8'd0;
    end else begin
      for (int i = 0; i < NUM_POCKETS; i++) begin
        if (hit_ok && int'(pocketHitIdx) == i) begin
          cnt[i] <= FLASH_LD;
        end else if (startOfFrame && cnt[i] != 8'd0) begin
          cnt[i] <= cnt[i] - 8'd1;
        end
      end
    end
  end

  // Saturating count of accepted hits
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      totalHits <= 8'd0;
    end else if (clearHits) begin
      totalHits <= 8'd0;
    end else if (hit_ok && totalHits != 8'hFF) begin
      totalHits <= totalHits + 8'd1;
    end
  end

endmodule

// File: tb/tb_pocket_array_draw.sv
// tb/tb_pocket_array_draw.sv - randomized model-based bench for pocket_array_draw
module tb_pocket_array_draw;

  localparam int N     = 6;
  localparam int LEFT  = 24;
  localparam int TOP   = 24;
  localparam int TW    = 592;
  localparam int TH    = 432;
  localparam int SZ    = 10;
  localparam int GR    = 2;
  localparam int FLASH = 15;

  logic              clk = 1'b0;
  logic              resetN;
  logic              startOfFrame;
  logic signed [10:0] pixelX, pixelY;
  logic              pocketHit;
  logic [2:0]        pocketHitIdx;
  logic              clearHits;
  logic              drawingRequest;
  logic [2:0]        pocketId;
  logic signed [10:0] offsetX, offsetY;
  logic [5:0]        flashMask;
  logic [7:0]        totalHits;

  int checks = 0;
  int errors = 0;
  int cnt_m [N];
  int hits_m;

  always #5 clk = ~clk;

  pocket_array_draw dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .pixelX(pixelX), .pixelY(pixelY), .pocketHit(pocketHit),
    .pocketHitIdx(pocketHitIdx), .clearHits(clearHits),
    .drawingRequest(drawingRequest), .pocketId(pocketId),
    .offsetX(offsetX), .offsetY(offsetY),
    .flashMask(flashMask), .totalHits(totalHits)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int geo_x(input int i);
    return LEFT + (i % (N / 2)) * ((TW - SZ) / (N / 2 - 1));
  endfunction

  function automatic int geo_y(input int i);
    return (i < N / 2) ? TOP : TOP + TH - SZ;
  endfunction

  function automatic int mask_m();
    int m = 0;
    for (int i = 0; i < N; i++) if (cnt_m[i] > 0) m |= (1 << i);
    return m;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) cnt_m[i] = 0;
    hits_m = 0;
  endtask

  // Drive one cycle of inputs, predict, clock, then compare all outputs
  task automatic tick(input int px, input int py, input bit hit, input int idx,
                      input bit sof, input bit clr);
    int ed, eid, eox, eoy, g, lx, ly, w;
    pixelX = 11'(px); pixelY = 11'(py);
    pocketHit = hit; pocketHitIdx = 3'(idx);
    startOfFrame = sof; clearHits = clr;
    ed = 0; eid = 0; eox = 0; eoy = 0;
    for (int i = 0; i < N; i++) begin
      g  = (cnt_m[i] > 0) ? GR : 0;
      lx = geo_x(i) - g;
      ly = geo_y(i) - g;
      w  = SZ + 2 * g;
      if (ed == 0 && px >= lx && px < lx + w && py >= ly && py < ly + w) begin
        ed = 1; eid = i; eox = (px - lx) & 'h7FF; eoy = (py - ly) & 'h7FF;
      end
    end
    if (clr) begin
      model_reset();
    end else begin
      for (int i = 0; i < N; i++) begin
        if (hit && idx < N && idx == i) cnt_m[i] = FLASH;
        else if (sof && cnt_m[i] > 0) cnt_m[i]--;
      end
      if (hit && idx < N && hits_m < 255) hits_m++;
    end
    @(posedge clk);
    #1;
    check("draw", int'(drawingRequest), ed);
    check("id", int'(pocketId), eid);
    check("offx", int'(offsetX) & 'h7FF, eox);
    check("offy", int'(offsetY) & 'h7FF, eoy);
    check("flash", int'(flashMask), mask_m());
    check("hits", int'(totalHits), hits_m);
  endtask

  initial begin
    int k, px, py;
    resetN = 1'b0; startOfFrame = 0; pixelX = 0; pixelY = 0;
    pocketHit = 0; pocketHitIdx = 0; clearHits = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_draw", int'(drawingRequest), 0);
    check("rst_id", int'(pocketId), 0);
    check("rst_offx", int'(offsetX), 0);
    check("rst_offy", int'(offsetY), 0);
    check("rst_flash", int'(flashMask), 0);
    check("rst_hits", int'(totalHits), 0);
    resetN = 1'b1;

    tick(24, 24, 0, 0, 0, 0);
    check("p0_corner", int'(drawingRequest), 1);
    tick(33, 33, 0, 0, 0, 0);
    check("p0_far_offx", int'(offsetX), 9);
    tick(34, 24, 0, 0, 0, 0);
    check("p0_outside", int'(drawingRequest), 0);
    tick(315, 446, 0, 0, 0, 0);
    check("p4_id", int'(pocketId), 4);
    tick(606, 24, 0, 0, 0, 0);
    check("p2_id", int'(pocketId), 2);

    tick(0, 0, 1, 4, 0, 0);
    tick(313, 444, 0, 0, 0, 0);
    check("p4_grown_draw", int'(drawingRequest), 1);
    check("p4_flash", int'(flashMask), 6'b010000);
    for (int i = 0; i < 15; i++) tick(313, 444, 0, 0, 1, 0);
    tick(313, 444, 0, 0, 0, 0);
    check("p4_expired", int'(drawingRequest), 0);
    check("p4_flash_off", int'(flashMask), 0);

    tick(0, 0, 1, 1, 1, 0);
    tick(0, 0, 0, 0, 1, 0);
    tick(0, 0, 1, 7, 0, 0);
    check("bad_idx_hits", int'(totalHits), 2);

    for (int i = 0; i < 300; i++) tick(0, 0, 1, i % 6, 0, 0);
    check("sat_hits", int'(totalHits), 255);
    tick(0, 0, 1, 3, 0, 1);
    check("clr_hits", int'(totalHits), 0);
    check("clr_flash", int'(flashMask), 0);

    tick(0, 0, 1, 0, 0, 0);
    tick(22, 22, 0, 0, 0, 0);
    check("grown_pre_rst", int'(drawingRequest), 1);
    #2;
    resetN = 1'b0;
    #1;
    check("arst_draw", int'(drawingRequest), 0);
    check("arst_offx", int'(offsetX), 0);
    check("arst_flash", int'(flashMask), 0);
    check("arst_hits", int'(totalHits), 0);
    model_reset();
    @(negedge clk);
    resetN = 1'b1;
    tick(24, 24, 0, 0, 0, 0);
    tick(22, 22, 0, 0, 0, 0);
    check("nominal_after_rst", int'(drawingRequest), 0);

    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) != 0) begin
        k  = $urandom_range(0, N - 1);
        px = geo_x(k) + $urandom_range(0, 15) - 3;
        py = geo_y(k) + $urandom_range(0, 15) - 3;
      end else begin
        px = $urandom_range(0, 700) - 20;
        py = $urandom_range(0, 500) - 20;
      end
      tick(px, py, $urandom_range(0, 7) == 0, $urandom_range(0, 7),
           $urandom_range(0, 3) == 0, $urandom_range(0, 63) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pocket_array_draw.md
Name: pocket_array_draw

Overview:
- Parametrised successor to the single fixed black-hole position block.
- Generates N pocket (black hole) positions on the billiard table, laid out as two rows.
- Per pixel, registers a draw request, the pocket ID and the in-box offset, feeding the pocket bitmap/mux stage.
- Tracks ball-in-pocket events:
  - a per-pocket flash animation that grows the pocket box for a set number of frames;
  - a saturating total-hit counter.

Parameters:
- NUM_POCKETS, 6, number of pockets; even, >=4; N/2 per row.
- TABLE_LEFT, 24, X of top-left pocket corner (pixels).
- TABLE_TOP, 24, Y of top-row pocket corner (pixels).
- TABLE_W, 592, horizontal table span used for pocket spacing (pixels).
- TABLE_H, 432, vertical table span used for row spacing (pixels).
- POCKET_SIZE, 10, pocket box width and height (pixels).
- GROW, 2, pixels added on every side while flashing.
- FLASH_FRAMES, 15, flash duration in startOfFrame pulses; 1..255.

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-clock pulse per frame
- pixelX  in  11  current pixel X, signed
- pixelY  in  11  current pixel Y, signed
- pocketHit  in  1  one-clock pulse: ball entered pocket pocketHitIdx
- pocketHitIdx  in  clog2(NUM_POCKETS)  index of hit pocket
- clearHits  in  1  synchronous clear of hit counter and all flashes
- drawingRequest  out  1  pixel lies inside some pocket box
- pocketId  out  clog2(NUM_POCKETS)  index of the pocket being drawn
- offsetX  out  11  pixelX minus box left edge
- offsetY  out  11  pixelY minus box top edge
- flashMask  out  NUM_POCKETS  bit i = pocket i currently flashing
- totalHits  out  8  saturating count of accepted hits

Behaviour:
- Clock and reset: one clock, clk. resetN is asynchronous, active-low. All state is reset; everything else is synchronous to posedge clk.
- Reset values:
  - drawingRequest=0, pocketId=0, offsetX=0, offsetY=0.
  - flashMask=0, totalHits=0, all flash counters=0.
- Geometry (elaboration-time constants), with C = N/2:
  - Pocket i: row r = i / C, column c = i % C.
  - X_i = TABLE_LEFT + c*((TABLE_W-POCKET_SIZE)/(C-1)), using integer division.
  - Y_i = TABLE_TOP when r=0; TABLE_TOP+TABLE_H-POCKET_SIZE when r=1.
- Box of pocket i:
  - Nominal: [X_i, X_i+POCKET_SIZE-1] x [Y_i, Y_i+POCKET_SIZE-1].
  - While flashMask[i]=1, expanded by GROW on every side.
  - Comparisons are signed 11-bit.
- Draw path, registered with 1-clock latency:
  - Outputs at cycle t+1 reflect pixelX/pixelY at cycle t and flash state at cycle t.
  - If several boxes contain the pixel, the lowest index wins.
  - offsetX/offsetY are measured from the top-left corner of the box actually used, grown or nominal.
  - When no box contains the pixel: drawingRequest=0, pocketId=0, offsets=0.
- Flash counters: one 8-bit counter per pocket; flashMask[i] = (counter_i != 0).
- Per-cycle priority, highest first:
  1. clearHits: all counters=0, totalHits=0; pocketHit in the same cycle is ignored.
  2. pocketHit with pocketHitIdx < NUM_POCKETS:
     - counter[idx] <= FLASH_FRAMES, overriding any decrement this cycle;
     - totalHits += 1, saturating at 255.
  3. pocketHit with pocketHitIdx >= NUM_POCKETS: ignored; no count, no flash.
  4. startOfFrame: every nonzero counter not loaded this cycle decrements by 1.
- Re-hitting a flashing pocket reloads its counter to FLASH_FRAMES (retrigger) and still counts.
- Reset mid-flash clears all flashes and the hit count immediately; the draw outputs drop to 0 asynchronously.

Test Plan:
- Defaults; pixel (24,24) then (33,33) then (34,24) -> one cycle later each: draw=1,id=0,off=(0,0); draw=1,id=0,off=(9,9); draw=0.
- Pixel (315,446) -> draw=1, id=4, off=(0,0). Pixel (606,24) -> draw=1, id=2.
- pocketHit idx=4, then pixel (313,444) -> flashMask=6'b010000, totalHits=1, draw=1, id=4, off=(0,0). After 15 startOfFrame pulses: flashMask=0, same pixel gives draw=0.
- pocketHit idx=1 coincident with startOfFrame -> counter=15, not 14. Hit idx=7 -> totalHits unchanged, flashMask unchanged.
- 300 hits -> totalHits=255. clearHits together with pocketHit -> totalHits=0, flashMask=0.
- Assert resetN low mid-flash, with drawingRequest=1 -> all outputs 0 immediately; after release, pixel (24,24) draws with the nominal box.
